warp_scheduler_rr: RTL and testbench



---
 rtl/sched_pkg.sv | 30 +++
 rtl/warp_scheduler_rr_arbiter.sv | 26 ++
 rtl/warp_scheduler_rr.sv | 186 ++++++++++++++++++
 tb/tb_warp_scheduler_rr.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared state encodings and packet bit-position defaults for the round-robin warp scheduler.
package sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FETCH       = 4'd1,
    ST_DECODE      = 4'd2,
    ST_ISSUE       = 4'd3,
    ST_EXECUTE     = 4'd4,
    ST_UPDATE      = 4'd5,
    ST_STALLED_MEM = 4'd6,
    ST_TENSOR_BUSY = 4'd7,
    ST_SLEEP       = 4'd8,
    ST_READY       = 4'd9,
    ST_RESUME      = 4'd10,
    ST_DONE        = 4'd15
  } warp_state_t;

  localparam int unsigned DEF_PKT_W      = 64;
  localparam int unsigned DEF_TENSOR_BIT = 42;
  localparam int unsigned DEF_RET_BIT    = 41;
  localparam int unsigned DEF_MEMR_BIT   = 32;
  localparam int unsigned DEF_MEMW_BIT   = 33;

  // A warp may be granted the front-end only from these two states.
  function automatic logic is_candidate(input warp_state_t s);
    return (s == ST_READY) || (s == ST_RESUME);
  endfunction

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  always_comb begin : pick
    int unsigned idx;
    idx       = 0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/warp_scheduler_rr.sv
// Per-core warp scheduler: one warp owns the shared front-end, stalled warps wait in the
// background, and a round-robin arbiter hands the front-end to the next ready warp.
module warp_scheduler_rr
  import sched_pkg::*;
#(
  parameter int unsigned WARPS_PER_CORE = 4,
  parameter int unsigned PC_W           = 8,
  parameter int unsigned PKT_W          = DEF_PKT_W,
  parameter int unsigned TENSOR_BIT     = DEF_TENSOR_BIT,
  parameter int unsigned RET_BIT        = DEF_RET_BIT,
  parameter int unsigned MEMR_BIT       = DEF_MEMR_BIT,
  parameter int unsigned MEMW_BIT       = DEF_MEMW_BIT,
  parameter int unsigned INTERLEAVE     = 0,
  localparam int unsigned IDW = $clog2(WARPS_PER_CORE)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [PC_W-1:0]             entry_pc,
  input  logic [WARPS_PER_CORE-1:0]   warp_enable,
  input  logic                        fetch_done,
  input  logic [PKT_W-1:0]            decoded_packet,
  input  logic [WARPS_PER_CORE-1:0]   mem_done,
  input  logic [WARPS_PER_CORE-1:0]   tensor_done,
  input  logic                        power_sleep_req,
  input  logic [PC_W-1:0]             next_pc,
  output logic [PC_W-1:0]             current_pc,
  output logic [3:0]                  core_state,
  output logic [IDW-1:0]              active_warp_id,
  output logic                        active_valid,
  output logic [4*WARPS_PER_CORE-1:0] warp_state,
  output logic [WARPS_PER_CORE-1:0]   warp_issue_enable,
  output logic                        done
);

  localparam int unsigned N = WARPS_PER_CORE;

  warp_state_t     st [N];
  logic [PC_W-1:0] pc [N];
  logic [N-1:0]    mem_pend;
  logic [N-1:0]    tensor_pend;
  logic [N-1:0]    ret_flag;
  logic [IDW-1:0]  rr_ptr;
  logic            started;

  logic [N-1:0]    cand;
  logic            all_idle;
  logic            all_done;
  logic            others_ready;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_valid;

  logic            is_tensor;
  logic            is_mem;
  logic            unused_pkt;

  assign is_tensor  = decoded_packet[TENSOR_BIT];
  assign is_mem     = decoded_packet[MEMR_BIT] | decoded_packet[MEMW_BIT];
  assign unused_pkt = ^decoded_packet;

  always_comb begin
    cand         = '0;
    all_idle     = 1'b1;
    all_done     = 1'b1;
    others_ready = 1'b0;
    for (int unsigned w = 0; w < N; w++) begin
      cand[w] = is_candidate(st[w]);
      if (st[w] != ST_IDLE) all_idle = 1'b0;
      if (st[w] != ST_DONE) all_done = 1'b0;
      if (cand[w] && (IDW'(w) != active_warp_id)) others_ready = 1'b1;
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req       (cand),
    .ptr       (rr_ptr),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Front-end steps and background event capture touch disjoint states, so both
  // may assign st[w] in the same cycle without overriding each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned w = 0; w < N; w++) begin
        st[w] <= ST_IDLE;
        pc[w] <= '0;
      end
      mem_pend       <= '0;
      tensor_pend    <= '0;
      ret_flag       <= '0;
      rr_ptr         <= '0;
      started        <= 1'b0;
      active_valid   <= 1'b0;
      active_warp_id <= '0;
      done           <= 1'b0;
    end else if (start && all_idle) begin
      for (int unsigned w = 0; w < N; w++) begin
        if (warp_enable[w]) begin
          st[w] <= ST_READY;
          pc[w] <= entry_pc;
        end else begin
          st[w] <= ST_DONE;
        end
      end
      started <= 1'b1;
      done    <= 1'b0;
    end else begin
      if (started && all_done) done <= 1'b1;

      for (int unsigned w = 0; w < N; w++) begin
        if (active_valid && (active_warp_id == IDW'(w))) begin
          case (st[w])
            ST_FETCH:   if (fetch_done) st[w] <= ST_DECODE;
            ST_DECODE:  st[w] <= ST_ISSUE;
            ST_ISSUE: begin
              ret_flag[w] <= decoded_packet[RET_BIT];
              if (is_tensor) begin
                st[w]        <= ST_TENSOR_BUSY;
                active_valid <= 1'b0;
              end else if (is_mem) begin
                st[w]        <= ST_STALLED_MEM;
                active_valid <= 1'b0;
              end else begin
                st[w] <= ST_EXECUTE;
              end
            end
            ST_EXECUTE: st[w] <= ST_UPDATE;
            ST_UPDATE: begin
              if (ret_flag[w]) begin
                st[w]        <= ST_DONE;
                active_valid <= 1'b0;
              end else begin
                pc[w] <= next_pc;
                if (power_sleep_req) begin
                  st[w]        <= ST_SLEEP;
                  active_valid <= 1'b0;
                end else if ((INTERLEAVE != 0) && others_ready) begin
                  st[w]        <= ST_READY;
                  active_valid <= 1'b0;
                end else begin
                  st[w] <= ST_FETCH;
                end
              end
            end
            default: ;
          endcase
        end

        if ((st[w] == ST_STALLED_MEM) && mem_pend[w]) begin
          st[w]       <= ST_RESUME;
          mem_pend[w] <= 1'b0;
        end else if (mem_done[w] && ((st[w] == ST_ISSUE) || (st[w] == ST_STALLED_MEM))) begin
          mem_pend[w] <= 1'b1;
        end

        if ((st[w] == ST_TENSOR_BUSY) && tensor_pend[w]) begin
          st[w]          <= ST_RESUME;
          tensor_pend[w] <= 1'b0;
        end else if (tensor_done[w] && ((st[w] == ST_ISSUE) || (st[w] == ST_TENSOR_BUSY))) begin
          tensor_pend[w] <= 1'b1;
        end

        if ((st[w] == ST_SLEEP) && !power_sleep_req) st[w] <= ST_READY;
      end

      if (!active_valid && gnt_valid) begin
        active_warp_id <= gnt_idx;
        active_valid   <= 1'b1;
        st[gnt_idx]    <= (st[gnt_idx] == ST_RESUME) ? ST_EXECUTE : ST_FETCH;
        rr_ptr         <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_comb begin
    current_pc        = pc[active_warp_id];
    core_state        = active_valid ? st[active_warp_id] : ST_IDLE;
    warp_issue_enable = '0;
    if (active_valid && (st[active_warp_id] == ST_ISSUE))
      warp_issue_enable[active_warp_id] = 1'b1;
    warp_state = '0;
    for (int unsigned w = 0; w < N; w++) warp_state[4*w +: 4] = st[w];
  end

endmodule

// File: tb/tb_warp_scheduler_rr.sv
// Self-checking bench: acts as fetcher/decoder for the active warp and scores grants and state traces.
module tb_warp_scheduler_rr;
  import sched_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned PC_W  = 8;
  localparam int unsigned PKT_W = 64;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start = 1'b0;
  logic [PC_W-1:0]  entry_pc = '0;
  logic [N-1:0]     warp_enable = '0;
  logic             fetch_done = 1'b0;
  logic [PKT_W-1:0] decoded_packet = '0;
  logic [N-1:0]     mem_done = '0;
  logic [N-1:0]     tensor_done = '0;
  logic             power_sleep_req = 1'b0;
  logic [PC_W-1:0]  next_pc = '0;
  logic [PC_W-1:0]  current_pc;
  logic [3:0]       core_state;
  logic [1:0]       active_warp_id;
  logic             active_valid;
  logic [4*N-1:0]   warp_state;
  logic [N-1:0]     warp_issue_enable;
  logic             done;

  warp_scheduler_rr #(
    .WARPS_PER_CORE(N),
    .PC_W          (PC_W),
    .PKT_W         (PKT_W),
    .INTERLEAVE    (1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .entry_pc         (entry_pc),
    .warp_enable      (warp_enable),
    .fetch_done       (fetch_done),
    .decoded_packet   (decoded_packet),
    .mem_done         (mem_done),
    .tensor_done      (tensor_done),
    .power_sleep_req  (power_sleep_req),
    .next_pc          (next_pc),
    .current_pc       (current_pc),
    .core_state       (core_state),
    .active_warp_id   (active_warp_id),
    .active_valid     (active_valid),
    .warp_state       (warp_state),
    .warp_issue_enable(warp_issue_enable),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned     id;
    logic [3:0]      st;
    logic [PC_W-1:0] pc;
    int              gap;
  } grant_t;

  grant_t          exp_q[$];
  logic [3:0]      st_q[$];
  logic [3:0]      pipe_seq [5];
  int              checks = 0;
  int              errors = 0;
  logic            prev_valid = 1'b0;
  logic [3:0]      last_st = '0;
  int              low_run = 0;
  bit              trace_on = 1'b0;
  int unsigned     cur_id = 0;
  int              fetch_cnt = 0;
  logic [PC_W-1:0] ret_pc [N];
  logic [PC_W-1:0] load_pc [N];
  logic [PC_W-1:0] ten_pc [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_grant(input int unsigned id, input logic [3:0] s,
                              input logic [PC_W-1:0] p, input int gap);
    grant_t g;
    g.id = id; g.st = s; g.pc = p; g.gap = gap;
    exp_q.push_back(g);
  endtask

  task automatic monitor();
    grant_t g;
    if (active_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("grant_unexpected", 32'(active_warp_id), 32'hFFFF_FFFF);
      end else begin
        g = exp_q.pop_front();
        cur_id = g.id;
        check("grant_id", 32'(active_warp_id), g.id);
        check("grant_state", 32'(core_state), 32'(g.st));
        check("grant_pc", 32'(current_pc), 32'(g.pc));
        if (g.gap >= 0) check("grant_bubble", low_run, g.gap);
      end
    end
    if (active_valid && core_state == ST_ISSUE)
      check("issue_en", 32'(warp_issue_enable), 32'(1) << cur_id);
    else
      check("issue_en_idle", 32'(warp_issue_enable), 0);
    if (trace_on && active_valid && (!prev_valid || core_state != last_st)) begin
      if (st_q.size() == 0) check("trace_extra", 32'(core_state), 32'hFFFF);
      else check("trace_state", 32'(core_state), 32'(st_q.pop_front()));
    end
    last_st    = core_state;
    low_run    = active_valid ? 0 : low_run + 1;
    prev_valid = active_valid;
  endtask

  // Fetcher/decoder model: instruction kind is chosen by (active warp, pc).
  task automatic drive();
    int unsigned     w;
    logic [PC_W-1:0] p;
    w = 32'(active_warp_id);
    p = current_pc;
    if (active_valid && core_state == ST_FETCH) fetch_cnt++;
    else fetch_cnt = 0;
    fetch_done     = (fetch_cnt >= 2);
    decoded_packet = '0;
    if (p == ret_pc[w])  decoded_packet[DEF_RET_BIT]    = 1'b1;
    if (p == load_pc[w]) decoded_packet[DEF_MEMR_BIT]   = 1'b1;
    if (p == ten_pc[w])  decoded_packet[DEF_TENSOR_BIT] = 1'b1;
    next_pc = p + 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
    drive();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(active_valid), 0);
    check({tag, "_id"}, 32'(active_warp_id), 0);
    check({tag, "_pc"}, 32'(current_pc), 0);
    check({tag, "_core_state"}, 32'(core_state), 0);
    check({tag, "_issue_en"}, 32'(warp_issue_enable), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_warp_state"}, 32'(warp_state), 0);
  endtask

  task automatic do_reset();
    check("sb_drained", exp_q.size(), 0);
    check("trace_drained", st_q.size(), 0);
    exp_q.delete();
    st_q.delete();
    @(negedge clk);
    reset_n = 1'b0; start = 1'b0; mem_done = '0; tensor_done = '0;
    power_sleep_req = 1'b0; trace_on = 1'b0;
    for (int w = 0; w < N; w++) begin
      ret_pc[w] = 8'hF0; load_pc[w] = 8'hF1; ten_pc[w] = 8'hF2;
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    prev_valid = 1'b0;
    low_run = 0;
    @(negedge clk);
    drive();
  endtask

  task automatic kick(input logic [N-1:0] en, input logic [PC_W-1:0] p0);
    warp_enable = en;
    entry_pc    = p0;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_core(input logic [3:0] s, input string tag);
    int n = 0;
    while (!(active_valid && core_state == s) && n < 200) begin tick(); n++; end
    check(tag, 32'(active_valid && core_state == s), 1);
  endtask

  task automatic wait_warp(input int unsigned w, input logic [3:0] s, input string tag);
    int n = 0;
    while (warp_state[4*w +: 4] != s && n < 200) begin tick(); n++; end
    check(tag, 32'(warp_state[4*w +: 4]), 32'(s));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin tick(); n++; end
    check(tag, 32'(done), 1);
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    pipe_seq = '{ST_FETCH, ST_DECODE, ST_ISSUE, ST_EXECUTE, ST_UPDATE};
    #2 reset_n = 1'b0;
    #1 check_reset("por");

    // Single warp: one ALU instruction then RET.
    do_reset();
    ret_pc[0] = 8'h11;
    expect_grant(0, ST_FETCH, 8'h10, -1);
    repeat (2) foreach (pipe_seq[i]) st_q.push_back(pipe_seq[i]);
    trace_on = 1'b1;
    kick(4'b0001, 8'h10);
    wait_done("t1_done");
    trace_on = 1'b0;
    check("t1_warp_state", 32'(warp_state), 32'hFFFF);
    check("t1_pc", 32'(current_pc), 32'h11);
    check("t1_valid", 32'(active_valid), 0);

    // Memory stall hands the front-end to warp 1, warp 0 resumes into EXECUTE.
    do_reset();
    load_pc[0] = 8'h20; ret_pc[0] = 8'h21; ret_pc[1] = 8'h21;
    expect_grant(0, ST_FETCH,   8'h20, -1);
    expect_grant(1, ST_FETCH,   8'h20, 1);
    expect_grant(0, ST_EXECUTE, 8'h20, 1);
    expect_grant(1, ST_FETCH,   8'h21, 1);
    expect_grant(0, ST_FETCH,   8'h21, 1);
    kick(4'b0011, 8'h20);
    wait_warp(0, ST_STALLED_MEM, "t2_stall");
    wait_core(ST_FETCH, "t2_w1_fetch");
    mem_done = 4'b0001;
    tick();
    mem_done = '0;
    tick();
    check("t2_resume", 32'(warp_state[3:0]), 32'(ST_RESUME));
    check("t2_w1_owner", 32'(active_warp_id), 1);
    wait_done("t2_done");

    // mem_done in the same cycle as ISSUE is captured.
    do_reset();
    load_pc[0] = 8'h30; ret_pc[0] = 8'h31;
    expect_grant(0, ST_FETCH,   8'h30, -1);
    expect_grant(0, ST_EXECUTE, 8'h30, 2);
    kick(4'b0001, 8'h30);
    wait_core(ST_ISSUE, "t3_issue");
    mem_done = 4'b0001;
    tick();
    mem_done = '0;
    check("t3_stall", 32'(warp_state[3:0]), 32'(ST_STALLED_MEM));
    tick();
    check("t3_resume", 32'(warp_state[3:0]), 32'(ST_RESUME));
    wait_done("t3_done");

    // Interleaved fairness across four ALU-only warps.
    do_reset();
    expect_grant(0, ST_FETCH, 8'h40, -1);
    expect_grant(1, ST_FETCH, 8'h40, 1);
    expect_grant(2, ST_FETCH, 8'h40, 1);
    expect_grant(3, ST_FETCH, 8'h40, 1);
    expect_grant(0, ST_FETCH, 8'h41, 1);
    expect_grant(1, ST_FETCH, 8'h41, 1);
    kick(4'b1111, 8'h40);
    wait_sb("t4_order");

    // Sleep during UPDATE, wake on deassert with pc preserved.
    do_reset();
    ret_pc[0] = 8'h52;
    expect_grant(0, ST_FETCH, 8'h50, -1);
    expect_grant(0, ST_FETCH, 8'h51, 5);
    kick(4'b0001, 8'h50);
    wait_core(ST_UPDATE, "t5_update");
    power_sleep_req = 1'b1;
    tick();
    check("t5_sleep", 32'(warp_state[3:0]), 32'(ST_SLEEP));
    check("t5_release", 32'(active_valid), 0);
    repeat (3) tick();
    check("t5_hold", 32'(warp_state[3:0]), 32'(ST_SLEEP));
    power_sleep_req = 1'b0;
    tick();
    check("t5_ready", 32'(warp_state[3:0]), 32'(ST_READY));
    wait_done("t5_done");

    // Asynchronous reset while warp 2 waits on tensor work, with an event pending.
    do_reset();
    ten_pc[2] = 8'h60;
    expect_grant(2, ST_FETCH, 8'h60, -1);
    kick(4'b0100, 8'h60);
    wait_warp(2, ST_TENSOR_BUSY, "t6_busy");
    tensor_done = 4'b0100;
    tick();
    tensor_done = '0;
    #2 reset_n = 1'b0;
    #1 check_reset("t6_async");
    @(negedge clk);
    reset_n = 1'b1;
    tensor_done = 4'b0100;
    tick();
    tensor_done = '0;
    tick();
    check("t6_late_event", 32'(warp_state), 0);
    expect_grant(2, ST_FETCH, 8'h60, -1);
    kick(4'b0100, 8'h60);
    wait_warp(2, ST_TENSOR_BUSY, "t6_busy2");
    repeat (5) tick();
    check("t6_no_resume", 32'(warp_state[11:8]), 32'(ST_TENSOR_BUSY));
    check("t6_sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
